cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_pkg.sv | 13 +
 rtl/fill_counter.sv | 27 ++
 rtl/cache_fill_fsm.sv | 101 ++++++++++
 tb/tb_cache_fill_fsm.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache block fill controller: fill state encoding
// and default block geometry.
package cache_pkg;

    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_W    = $clog2(BLOCK_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear and increment enable; clear wins over
// increment so a new fill always starts from zero.
module fill_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: issues one read per block word, writes returning
// words into the data array in order and writes the tag with the last word.
//
//   state | meaning
//   IDLE  | no fill in progress; a miss is accepted and its block base latched
//   FILL  | requests issued until all words asked for; ends on the last return
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
    parameter int ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    output logic                           fsm_busy,
    output logic                           mem_read_en,
    output logic [ADDR_W-1:0]              memory_address,
    input  logic                           memory_data_valid,
    input  logic [15:0]                    memory_data,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] word_offset,
    output logic [15:0]                    fill_data,
    output logic                           write_tag_array
);

    import cache_pkg::*;

    localparam int OFF_W  = $clog2(BLOCK_WORDS);
    localparam int CNT_W  = OFF_W + 1;
    localparam int BYTE_W = OFF_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-BYTE_W){1'b1}}, {BYTE_W{1'b0}}};

    fill_state_t       r_state;
    logic [ADDR_W-1:0] r_base;

    logic [CNT_W-1:0]  w_issue_cnt;
    logic [CNT_W-1:0]  w_recv_cnt;
    logic [CNT_W-1:0]  w_issue_idx;
    logic              w_accept;
    logic              w_issuing;
    logic              w_receiving;
    logic              w_last_word;

    assign w_accept    = (r_state == IDLE) && miss_detected;
    assign w_issuing   = (r_state == FILL) && (w_issue_cnt < CNT_FULL);
    assign w_receiving = (r_state == FILL) && memory_data_valid;
    assign w_last_word = w_receiving && (w_recv_cnt == CNT_LAST);

    // Clamp so the address bus keeps showing the final request once issuing stops.
    assign w_issue_idx = (w_issue_cnt < CNT_FULL) ? w_issue_cnt : CNT_LAST;

    fill_counter #(.W(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_inc (w_issuing),
        .o_cnt (w_issue_cnt)
    );

    fill_counter #(.W(CNT_W)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_inc (w_receiving),
        .o_cnt (w_recv_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_base  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (miss_detected) begin
                        r_base  <= miss_address & BASE_MASK;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (w_last_word) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Busy covers the accept cycle combinationally so the pipeline never sees a gap.
    assign fsm_busy         = (r_state == FILL) || w_accept;
    assign mem_read_en      = w_issuing;
    assign memory_address   = r_base + ADDR_W'({w_issue_idx, 1'b0});
    assign write_data_array = w_receiving;
    assign word_offset      = w_recv_cnt[OFF_W-1:0];
    assign fill_data        = memory_data;
    assign write_tag_array  = w_last_word;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: reset/idle vector table, then fills
// driven by a latency-modelling memory with address and write scoreboards.
module tb_cache_fill_fsm;

    import cache_pkg::*;

    localparam int BW = cache_pkg::BLOCK_WORDS;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                miss_detected;
    logic [15:0]         miss_address;
    logic                fsm_busy;
    logic                mem_read_en;
    logic [15:0]         memory_address;
    logic                memory_data_valid;
    logic [15:0]         memory_data;
    logic                write_data_array;
    logic [OFFSET_W-1:0] word_offset;
    logic [15:0]         fill_data;
    logic                write_tag_array;

    cache_fill_fsm #(.BLOCK_WORDS(BW), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .word_offset       (word_offset),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OFFSET_W-1:0] off;
        logic [15:0]         data;
    } wr_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } pend_t;

    typedef struct {
        logic        rst;
        logic        miss;
        logic        vld;
        logic [15:0] data;
        logic        e_busy;
        logic        e_rd;
        logic        e_wr;
        logic        e_tag;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_addr_q[$];
    wr_t         exp_wr_q[$];
    pend_t       pend_q[$];
    vec_t        vecs[6];

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [15:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%04h expected nothing at %0t", name, act, $time);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'd3) ^ 16'hC35A;
    endfunction

    // Entered and left just after a rising edge, where the current cycle's inputs are driven.
    task automatic do_fill(input logic [15:0] addr, input int lat_lo, input int lat_hi,
                           input bit gaps, input int abort_after, input bit hold_after,
                           input logic [15:0] next_addr);
        logic [15:0] base;
        logic [15:0] ea;
        wr_t         ew;
        pend_t       p;
        int          last_due, next_off, due;
        int          n_rd, n_wr, n_tag, first_rd, first_wr;
        bit          cur_vld, cur_tag, done, aborted;
        base = addr & 16'hFFF0;
        last_due = -1; next_off = 0;
        n_rd = 0; n_wr = 0; n_tag = 0; first_rd = -1; first_wr = -1;
        cur_vld = 0; cur_tag = 0; done = 0; aborted = 0;
        for (int i = 0; i < BW; i++) exp_addr_q.push_back(base + 16'(2 * i));
        miss_detected     = 1'b1;
        miss_address      = addr;
        memory_data_valid = 1'b0;
        memory_data       = 16'($urandom);
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            check1("busy_during_fill", fsm_busy, 1'b1);
            check1("rd_en_window", mem_read_en, (k >= 1 && k <= BW));
            if (mem_read_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = k;
                if (exp_addr_q.size() == 0) fail_now("extra_read", memory_address);
                else begin
                    ea = exp_addr_q.pop_front();
                    check16("rd_addr", memory_address, ea);
                end
                due = k + $urandom_range(lat_lo, lat_hi);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_q.push_back('{due, mem_word(memory_address)});
            end
            check1("wr_en", write_data_array, cur_vld);
            check1("tag_wr", write_tag_array, cur_tag);
            if (write_data_array) begin
                n_wr++;
                if (first_wr < 0) first_wr = k;
                if (exp_wr_q.size() == 0) fail_now("extra_write", fill_data);
                else begin
                    ew = exp_wr_q.pop_front();
                    check16("word_offset", 16'(word_offset), 16'(ew.off));
                    check16("fill_data", fill_data, ew.data);
                end
            end
            if (write_tag_array) n_tag++;
            if (cur_tag) done = 1;
            if (abort_after > 0 && n_wr == abort_after) begin
                #2;
                memory_data_valid = 1'b1;
                rst_n = 1'b0;
                #1;
                check1("abort_rd_en", mem_read_en, 1'b0);
                check1("abort_wr_en", write_data_array, 1'b0);
                check1("abort_tag", write_tag_array, 1'b0);
                check1("abort_busy", fsm_busy, 1'b1);
                check16("abort_addr", memory_address, 16'h0000);
                check16("abort_offset", 16'(word_offset), 16'h0000);
                aborted = 1;
                done = 1;
            end
            if (!done) begin
                @(posedge clk);
                #1;
                miss_address = 16'($urandom);
                cur_vld = 0;
                cur_tag = 0;
                if (pend_q.size() > 0 && pend_q[0].due <= k + 1 &&
                    !(gaps && $urandom_range(0, 3) == 0)) begin
                    p = pend_q.pop_front();
                    cur_vld = 1;
                    cur_tag = (next_off == BW - 1);
                    exp_wr_q.push_back('{OFFSET_W'(next_off), p.data});
                    next_off++;
                    memory_data_valid = 1'b1;
                    memory_data = p.data;
                end else begin
                    memory_data_valid = 1'b0;
                    memory_data = 16'($urandom);
                end
            end
        end
        if (!done) fail_now("fill_timeout", 16'(n_wr));
        if (aborted) begin
            exp_addr_q.delete();
            exp_wr_q.delete();
            pend_q.delete();
        end else begin
            check16("n_reads", 16'(n_rd), 16'(BW));
            check16("n_writes", 16'(n_wr), 16'(BW));
            check16("n_tags", 16'(n_tag), 16'd1);
            check16("addr_q_left", 16'(exp_addr_q.size()), 16'd0);
            check16("wr_q_left", 16'(exp_wr_q.size()), 16'd0);
            if (lat_lo == lat_hi && !gaps)
                check16("first_wr_latency", 16'(first_wr - first_rd), 16'(lat_lo));
            @(posedge clk);
            #1;
            miss_detected     = hold_after;
            miss_address      = next_addr;
            memory_data_valid = 1'b0;
            if (!hold_after) begin
                @(negedge clk);
                check1("busy_after_fill", fsm_busy, 1'b0);
                check1("rd_after_fill", mem_read_en, 1'b0);
                check1("wr_after_fill", write_data_array, 1'b0);
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h5678, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; miss_detected = 1'b0; miss_address = 16'h0000;
        memory_data_valid = 1'b0; memory_data = 16'h0000;

        for (int v = 0; v < 6; v++) begin
            @(posedge clk);
            #1;
            rst_n = vecs[v].rst; miss_detected = vecs[v].miss;
            memory_data_valid = vecs[v].vld; memory_data = vecs[v].data;
            @(negedge clk);
            check1("vec_busy", fsm_busy, vecs[v].e_busy);
            check1("vec_rd_en", mem_read_en, vecs[v].e_rd);
            check1("vec_wr_en", write_data_array, vecs[v].e_wr);
            check1("vec_tag", write_tag_array, vecs[v].e_tag);
            check16("vec_fill_data", fill_data, vecs[v].data);
        end
        check16("reset_addr", memory_address, 16'h0000);
        check16("reset_offset", 16'(word_offset), 16'h0000);
        @(posedge clk);
        #1;
        memory_data_valid = 1'b0;

        do_fill(16'h1236, 4, 4, 1'b0, 0, 1'b0, 16'h0000);

        // Returned data while idle must be ignored entirely.
        memory_data_valid = 1'b1; memory_data = 16'hBEEF;
        repeat (3) begin
            @(negedge clk);
            check1("idle_wr_en", write_data_array, 1'b0);
            check1("idle_tag", write_tag_array, 1'b0);
            check1("idle_busy", fsm_busy, 1'b0);
            check16("idle_fill_data", fill_data, 16'hBEEF);
            @(posedge clk);
            #1;
        end
        memory_data_valid = 1'b0;
        @(negedge clk);
        check16("idle_addr_hold", memory_address, 16'h123E);
        check16("idle_offset_hold", 16'(word_offset), 16'h0000);
        @(posedge clk);
        #1;

        do_fill(16'h0040, 3, 3, 1'b0, 0, 1'b1, 16'h8000);
        do_fill(16'h8000, 2, 2, 1'b0, 0, 1'b0, 16'h0000);

        do_fill(16'h2468, 3, 3, 1'b0, 3, 1'b0, 16'h0000);
        repeat (2) begin
            @(negedge clk);
            check1("in_reset_tag", write_tag_array, 1'b0);
            check1("in_reset_wr_en", write_data_array, 1'b0);
            check1("in_reset_rd_en", mem_read_en, 1'b0);
        end
        @(posedge clk);
        #1;
        memory_data_valid = 1'b0;
        rst_n = 1'b1;
        do_fill(16'h2468, 5, 5, 1'b0, 0, 1'b0, 16'h0000);

        for (int f = 0; f < 4; f++)
            do_fill(16'($urandom), 1, 10, 1'b1, 0, 1'b0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
